midi_rx_decoder: RTL and testbench



---
 rtl/midi_rx_decoder.sv | 193 +++++++++++++++++++
 tb/tb_midi_rx_decoder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/midi_rx_decoder.sv
`timescale 1ns/1ps
// MIDI receive path: 8N1 UART deserialiser followed by a running-status parser
// that reports note-on, note-off and control-change events.
module midi_rx_decoder #(
  parameter int CLKS_PER_BIT = 320,
  parameter int CNT_W        = 9
) (
  input  logic       SYSCLK,
  input  logic       SYSRESET,
  input  logic       MIDI_RX,
  output logic       EVT_VALID,
  output logic [1:0] EVT_TYPE,
  output logic [3:0] EVT_CHAN,
  output logic [6:0] EVT_DATA1,
  output logic [6:0] EVT_DATA2,
  output logic       BYTE_VALID,
  output logic [7:0] RX_BYTE,
  output logic       FRAME_ERR
);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_t;
  typedef enum logic [1:0] {P_NONE, P_DATA1, P_DATA2} parse_state_t;

  logic rx_meta, rx_s;

  uart_state_t      ustate, ustate_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       bit_idx, bit_idx_nx;
  logic [7:0]       shreg, shreg_nx;
  logic             byte_done, frame_bad;

  parse_state_t pstate, pstate_nx;
  logic [7:0]   status, status_nx;
  logic [6:0]   data1, data1_nx;
  logic         emit;
  logic [1:0]   emit_type;

  // Synchroniser idles high so reset never looks like a start bit
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= MIDI_RX;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      ustate     <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      BYTE_VALID <= 1'b0;
      FRAME_ERR  <= 1'b0;
      RX_BYTE    <= '0;
    end else begin
      ustate     <= ustate_nx;
      cnt        <= cnt_nx;
      bit_idx    <= bit_idx_nx;
      shreg      <= shreg_nx;
      BYTE_VALID <= byte_done;
      FRAME_ERR  <= frame_bad;
      if (byte_done) RX_BYTE <= shreg;
    end
  end

  // Start bit is re-checked at its midpoint; every later sample lands mid-bit
  always_comb begin
    ustate_nx  = ustate;
    cnt_nx     = cnt + CNT_ONE;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    byte_done  = 1'b0;
    frame_bad  = 1'b0;
    case (ustate)
      IDLE: begin
        cnt_nx     = '0;
        bit_idx_nx = '0;
        if (!rx_s) ustate_nx = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_nx    = '0;
          ustate_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_nx     = '0;
          shreg_nx   = {rx_s, shreg[7:1]};
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) ustate_nx = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_nx = '0;
          if (rx_s) begin
            byte_done = 1'b1;
            ustate_nx = IDLE;
          end else begin
            frame_bad = 1'b1;
            ustate_nx = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_nx = '0;
        if (rx_s) ustate_nx = IDLE;
      end
      default: ustate_nx = IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      pstate    <= P_NONE;
      status    <= '0;
      data1     <= '0;
      EVT_VALID <= 1'b0;
      EVT_TYPE  <= '0;
      EVT_CHAN  <= '0;
      EVT_DATA1 <= '0;
      EVT_DATA2 <= '0;
    end else begin
      pstate    <= pstate_nx;
      status    <= status_nx;
      data1     <= data1_nx;
      EVT_VALID <= emit;
      if (emit) begin
        EVT_TYPE  <= emit_type;
        EVT_CHAN  <= status[3:0];
        EVT_DATA1 <= data1;
        EVT_DATA2 <= RX_BYTE[6:0];
      end
    end
  end

  // Realtime bytes (F8-FF) pass through without disturbing the message in progress
  always_comb begin
    pstate_nx = pstate;
    status_nx = status;
    data1_nx  = data1;
    emit      = 1'b0;
    emit_type = 2'd0;
    if (FRAME_ERR) begin
      pstate_nx = P_NONE;
      status_nx = '0;
    end else if (BYTE_VALID) begin
      if (RX_BYTE[7]) begin
        if (RX_BYTE[7:3] != 5'b11111) begin
          if (RX_BYTE[7:4] == 4'hF) begin
            pstate_nx = P_NONE;
            status_nx = '0;
          end else begin
            pstate_nx = P_DATA1;
            status_nx = RX_BYTE;
          end
        end
      end else begin
        case (pstate)
          P_DATA1: begin
            data1_nx  = RX_BYTE[6:0];
            pstate_nx = (status[7:4] == 4'hC || status[7:4] == 4'hD) ? P_DATA1 : P_DATA2;
          end
          P_DATA2: begin
            pstate_nx = P_DATA1;
            case (status[7:4])
              4'h8: emit = 1'b1;
              4'h9: begin
                emit      = 1'b1;
                emit_type = (RX_BYTE[6:0] == 7'd0) ? 2'd0 : 2'd1;
              end
              4'hB: begin
                emit      = 1'b1;
                emit_type = 2'd2;
              end
              default: emit = 1'b0;
            endcase
          end
          default: pstate_nx = pstate;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_rx_decoder.sv
`timescale 1ns/1ps
// Directed bench for midi_rx_decoder: serialises MIDI bytes onto MIDI_RX and
// checks received bytes, framing errors and decoded events.
module tb_midi_rx_decoder;

  localparam int CPB = 320;
  localparam int GAP = 20;

  typedef struct packed {
    logic [1:0] t;
    logic [3:0] c;
    logic [6:0] d1;
    logic [6:0] d2;
  } evt_t;

  logic       SYSCLK = 1'b0;
  logic       SYSRESET;
  logic       MIDI_RX;
  logic       EVT_VALID;
  logic [1:0] EVT_TYPE;
  logic [3:0] EVT_CHAN;
  logic [6:0] EVT_DATA1;
  logic [6:0] EVT_DATA2;
  logic       BYTE_VALID;
  logic [7:0] RX_BYTE;
  logic       FRAME_ERR;

  int checks = 0;
  int passed = 0;
  int bv_count = 0, fe_count = 0, evt_count = 0, evt_late = 0;
  int bv0, fe0, ev0;
  logic bv_prev = 1'b0;
  evt_t evq[$];

  midi_rx_decoder #(.CLKS_PER_BIT(CPB), .CNT_W(9)) dut (
    .SYSCLK(SYSCLK), .SYSRESET(SYSRESET), .MIDI_RX(MIDI_RX),
    .EVT_VALID(EVT_VALID), .EVT_TYPE(EVT_TYPE), .EVT_CHAN(EVT_CHAN),
    .EVT_DATA1(EVT_DATA1), .EVT_DATA2(EVT_DATA2),
    .BYTE_VALID(BYTE_VALID), .RX_BYTE(RX_BYTE), .FRAME_ERR(FRAME_ERR)
  );

  always #50 SYSCLK = ~SYSCLK;

  // Every event must follow a BYTE_VALID pulse on the immediately preceding cycle
  always @(negedge SYSCLK) begin
    evt_t e;
    if (BYTE_VALID) bv_count++;
    if (FRAME_ERR) fe_count++;
    if (EVT_VALID) begin
      evt_count++;
      if (!bv_prev) evt_late++;
      e = {EVT_TYPE, EVT_CHAN, EVT_DATA1, EVT_DATA2};
      evq.push_back(e);
    end
    bv_prev = BYTE_VALID;
  end

  function automatic evt_t mkEvt(input logic [1:0] t, input logic [3:0] c,
                                 input logic [6:0] d1, input logic [6:0] d2);
    return {t, c, d1, d2};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic checkEvent(input string tag, input evt_t expected);
    evt_t e;
    if (evq.size() == 0) begin
      checkOutput({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      e = evq.pop_front();
      checkOutput(tag, 32'(e), 32'(expected));
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    MIDI_RX = 1'b0;
    repeat (CPB) @(negedge SYSCLK);
    for (int i = 0; i < 8; i++) begin
      MIDI_RX = b[i];
      repeat (CPB) @(negedge SYSCLK);
    end
    MIDI_RX = stop_bit;
    repeat (CPB) @(negedge SYSCLK);
    MIDI_RX = 1'b1;
    repeat (GAP) @(negedge SYSCLK);
  endtask

  task automatic snapshot();
    bv0 = bv_count;
    fe0 = fe_count;
    ev0 = evt_count;
  endtask

  initial begin
    SYSRESET = 1'b1;
    MIDI_RX  = 1'b1;
    repeat (5) @(negedge SYSCLK);
    checkOutput("rst_evt_valid", 32'(EVT_VALID), 32'd0);
    checkOutput("rst_evt_fields", 32'({EVT_TYPE, EVT_CHAN, EVT_DATA1, EVT_DATA2}), 32'd0);
    checkOutput("rst_byte_valid", 32'(BYTE_VALID), 32'd0);
    checkOutput("rst_rx_byte", 32'(RX_BYTE), 32'd0);
    checkOutput("rst_frame_err", 32'(FRAME_ERR), 32'd0);
    SYSRESET = 1'b0;
    repeat (10) @(negedge SYSCLK);

    $display("[TB] note on 0x93 0x3C 0x64");
    snapshot();
    applyStimulus(8'h93, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'h64, 1'b1);
    checkOutput("t1_byte_count", 32'(bv_count - bv0), 32'd3);
    checkOutput("t1_evt_count", 32'(evt_count - ev0), 32'd1);
    checkEvent("t1_evt", mkEvt(2'd1, 4'd3, 7'h3C, 7'h64));
    checkOutput("t1_rx_byte", 32'(RX_BYTE), 32'h64);
    checkOutput("t1_fields_held", 32'({EVT_TYPE, EVT_CHAN, EVT_DATA1, EVT_DATA2}),
                32'(mkEvt(2'd1, 4'd3, 7'h3C, 7'h64)));

    $display("[TB] running status 0x90 0x40 0x7F 0x41 0x00");
    snapshot();
    applyStimulus(8'h90, 1'b1);
    applyStimulus(8'h40, 1'b1);
    applyStimulus(8'h7F, 1'b1);
    applyStimulus(8'h41, 1'b1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("t2_evt_count", 32'(evt_count - ev0), 32'd2);
    checkEvent("t2_evt0", mkEvt(2'd1, 4'd0, 7'h40, 7'h7F));
    checkEvent("t2_evt1", mkEvt(2'd0, 4'd0, 7'h41, 7'h00));

    $display("[TB] control change with interleaved realtime bytes");
    snapshot();
    applyStimulus(8'hB5, 1'b1);
    applyStimulus(8'hF8, 1'b1);
    applyStimulus(8'h07, 1'b1);
    applyStimulus(8'hFE, 1'b1);
    applyStimulus(8'h50, 1'b1);
    checkOutput("t3_byte_count", 32'(bv_count - bv0), 32'd5);
    checkOutput("t3_evt_count", 32'(evt_count - ev0), 32'd1);
    checkEvent("t3_evt", mkEvt(2'd2, 4'd5, 7'h07, 7'h50));

    $display("[TB] 100-cycle glitch then note off");
    snapshot();
    MIDI_RX = 1'b0;
    repeat (100) @(negedge SYSCLK);
    MIDI_RX = 1'b1;
    repeat (400) @(negedge SYSCLK);
    checkOutput("t4_glitch_bytes", 32'(bv_count - bv0), 32'd0);
    checkOutput("t4_glitch_ferr", 32'(fe_count - fe0), 32'd0);
    applyStimulus(8'h80, 1'b1);
    applyStimulus(8'h30, 1'b1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("t4_evt_count", 32'(evt_count - ev0), 32'd1);
    checkEvent("t4_evt", mkEvt(2'd0, 4'd0, 7'h30, 7'h00));

    $display("[TB] framing error clears running status");
    snapshot();
    applyStimulus(8'h90, 1'b0);
    repeat (CPB) @(negedge SYSCLK);
    checkOutput("t5_frame_err", 32'(fe_count - fe0), 32'd1);
    checkOutput("t5_no_byte", 32'(bv_count - bv0), 32'd0);
    checkOutput("t5_rx_byte_kept", 32'(RX_BYTE), 32'h00);
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'h64, 1'b1);
    checkOutput("t5_data_bytes", 32'(bv_count - bv0), 32'd2);
    checkOutput("t5_no_evt", 32'(evt_count - ev0), 32'd0);

    $display("[TB] reset during data bit 4 of 0x91");
    MIDI_RX = 1'b0;
    repeat (CPB) @(negedge SYSCLK);
    for (int i = 0; i < 4; i++) begin
      MIDI_RX = (8'h91 >> i) & 8'h01;
      repeat (CPB) @(negedge SYSCLK);
    end
    MIDI_RX = 1'b1;
    repeat (CPB / 2) @(negedge SYSCLK);
    SYSRESET = 1'b1;
    @(negedge SYSCLK);
    checkOutput("t6_rst_evt_fields", 32'({EVT_TYPE, EVT_CHAN, EVT_DATA1, EVT_DATA2}), 32'd0);
    checkOutput("t6_rst_rx_byte", 32'(RX_BYTE), 32'd0);
    checkOutput("t6_rst_pulses", 32'({EVT_VALID, BYTE_VALID, FRAME_ERR}), 32'd0);
    repeat (3) @(negedge SYSCLK);
    SYSRESET = 1'b0;
    repeat (2 * CPB) @(negedge SYSCLK);
    snapshot();
    applyStimulus(8'h91, 1'b1);
    applyStimulus(8'h20, 1'b1);
    applyStimulus(8'h10, 1'b1);
    checkOutput("t6_byte_count", 32'(bv_count - bv0), 32'd3);
    checkOutput("t6_evt_count", 32'(evt_count - ev0), 32'd1);
    checkEvent("t6_evt", mkEvt(2'd1, 4'd1, 7'h20, 7'h10));

    checkOutput("evt_timing", 32'(evt_late), 32'd0);
    checkOutput("evt_queue_empty", 32'(evq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
